cntr_sweep_ctrl: RTL

- Command-side controller for the 48-bit loadable up/down counter slice (DSP48E counter with LOAD/C_IN/ADD_SUB in, CNTR_OUT back).
- Drives LOAD, C_IN and ADD_SUB so the counter sweeps as a triangle between a programmable floor and ceiling.
- Keeps a shadow model of the counter and checks the returned CNTR_OUT against it.
- Used as the stimulus/sequencing front end for DSP48E counter applications (address sweepers, triangle-wave generators).

---
 rtl/dsp48e_app_pkg.sv | 7 +
 rtl/cntr_shadow_chk.sv | 39 +++
 rtl/cntr_sweep_ctrl.sv | 81 ++++++++
 3 files changed

// File: rtl/dsp48e_app_pkg.sv
// dsp48e_app_pkg: shared constants for DSP48E counter applications
package dsp48e_app_pkg;
  localparam int DEF_WIDTH = 48;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_UP = 2'd1, ST_DOWN = 2'd2} state_e;
endpackage

// File: rtl/cntr_shadow_chk.sv
// cntr_shadow_chk: shadow counter model, PIPE-aligned delay line and sticky mismatch flag
module cntr_shadow_chk #(
  parameter int WIDTH = 48,
  parameter int PIPE  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] c_in_i,
  input  logic             add_sub_i,
  input  logic             busy_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] cntr_i,
  output logic [WIDTH-1:0] s_next_o,
  output logic             mismatch_o
);
  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] pipe_q [PIPE];
  logic [2:0]       age_q;
  always_comb s_d = load_i ? c_in_i : add_sub_i ? pipe_q[0] + 1'b1 : pipe_q[0] - 1'b1;
  assign s_next_o = s_d;
  // pipe_q[0] is the shadow value itself; the tail lines it up with CNTR_OUT
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i < PIPE; i++) pipe_q[i] <= '0;
      age_q      <= '0;
      mismatch_o <= 1'b0;
    end else begin
      pipe_q[0] <= s_d;
      for (int i = 1; i < PIPE; i++) pipe_q[i] <= pipe_q[i-1];
      if (clr_i) begin
        age_q      <= '0;
        mismatch_o <= 1'b0;
      end else if (busy_i) begin
        if (age_q != 3'(PIPE)) age_q <= age_q + 3'd1;
        if (age_q == 3'(PIPE) && pipe_q[PIPE-1] != cntr_i) mismatch_o <= 1'b1;
      end
    end
endmodule

// File: rtl/cntr_sweep_ctrl.sv
// cntr_sweep_ctrl: drives a DSP48E up/down counter as a triangle sweep between LO and HI
// and checks the returned count against a shadow model.
module cntr_sweep_ctrl import dsp48e_app_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PIPE  = 1,
  parameter int SWP_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             STOP,
  input  logic [WIDTH-1:0] LO_VAL,
  input  logic [WIDTH-1:0] HI_VAL,
  input  logic [WIDTH-1:0] CNTR_OUT,
  output logic             LOAD,
  output logic [WIDTH-1:0] C_IN,
  output logic             ADD_SUB,
  output logic             BUSY,
  output logic             REV,
  output logic [SWP_W-1:0] SWEEP_CNT,
  output logic             CFG_ERR,
  output logic             MISMATCH
);
  state_e           state_q;
  logic [WIDTH-1:0] lo_q, hi_q, p_q, s_next;
  logic             start_ok;
  assign start_ok = state_q == ST_IDLE && START && !STOP && LO_VAL < HI_VAL;
  cntr_shadow_chk #(.WIDTH(WIDTH), .PIPE(PIPE)) u_chk (
    .clk_i(CLK), .rst_ni(RST_N), .load_i(LOAD), .c_in_i(C_IN), .add_sub_i(ADD_SUB),
    .busy_i(BUSY), .clr_i(start_ok), .cntr_i(CNTR_OUT), .s_next_o(s_next), .mismatch_o(MISMATCH)
  );
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      p_q       <= '0;
      LOAD      <= 1'b1;
      C_IN      <= '0;
      ADD_SUB   <= DIR_UP;
      BUSY      <= 1'b0;
      REV       <= 1'b0;
      SWEEP_CNT <= '0;
      CFG_ERR   <= 1'b0;
    end else begin
      REV     <= 1'b0;
      CFG_ERR <= 1'b0;
      if (state_q == ST_IDLE) begin
        LOAD <= 1'b1;
        C_IN <= p_q;
        if (start_ok) begin
          lo_q      <= LO_VAL;
          hi_q      <= HI_VAL;
          p_q       <= LO_VAL;
          C_IN      <= LO_VAL;
          ADD_SUB   <= DIR_UP;
          BUSY      <= 1'b1;
          SWEEP_CNT <= '0;
          state_q   <= ST_UP;
        end else if (START && !STOP) CFG_ERR <= 1'b1;
      end else if (STOP) begin
        LOAD    <= 1'b1;
        C_IN    <= p_q;
        BUSY    <= 1'b0;
        state_q <= ST_IDLE;
      end else begin
        // reversal decided on the value the counter takes at this edge
        LOAD <= 1'b0;
        if (state_q == ST_UP && s_next == hi_q) begin
          state_q <= ST_DOWN;
          ADD_SUB <= DIR_DN;
          REV     <= 1'b1;
        end else if (state_q != ST_UP && s_next == lo_q) begin
          state_q <= ST_UP;
          ADD_SUB <= DIR_UP;
          REV     <= 1'b1;
          if (~&SWEEP_CNT) SWEEP_CNT <= SWEEP_CNT + 1'b1;
        end
      end
    end
endmodule
